// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing checker.
//   W          : width of measurement counters and expected-value inputs
//   *_1080P    : CEA-861 1080p60 timing (2200 x 1125 total, 1920 x 1080 active)
//   *_SIM      : small frame used to exercise the checker in simulation
//   state_t    : checker FSM state encoding
package vga_pkg;

  localparam int W = 12;

  localparam int H_PERIOD_1080P = 2200;
  localparam int H_ACTIVE_1080P = 1920;
  localparam int V_PERIOD_1080P = 1125;
  localparam int V_ACTIVE_1080P = 1080;

  localparam int H_PERIOD_SIM = 20;
  localparam int H_ACTIVE_SIM = 12;
  localparam int V_PERIOD_SIM = 10;
  localparam int V_ACTIVE_SIM = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

endpackage

// File: rtl/vga_timing_checker_sync_edge_det.sv
// Two-stage input register with edge detection for one video control line.
//   clk, reset : pixel clock, asynchronous active-high reset
//   din        : raw input from the timing generator
//   q          : first register stage (din delayed by one clock)
//   rise, fall : single-cycle edge strobes, comparing stage 2 against stage 1
// IDLE_LVL is the level both stages take in reset, so no spurious edge is
// seen when reset releases onto an idle line.
module sync_edge_det #(
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic q1;
  logic q2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q1 <= IDLE_LVL;
      q2 <= IDLE_LVL;
    end else begin
      q1 <= din;
      q2 <= q1;
    end
  end

  assign q    = q1;
  assign rise = ~q2 & q1;
  assign fall = q2 & ~q1;

endmodule

// File: rtl/vga_timing_checker.sv
// Passive monitor of VGA/HDMI sync timing.
// Measures line period, active width, lines per frame and active lines,
// compares each finished frame with exp_*, tracks lock and counts bad frames.
//   clk, reset      : pixel clock, asynchronous active-high reset
//   vga_hs, vga_vs  : active-low syncs; vga_de : active-high data enable
//   exp_*           : expected timing, sampled at each frame compare
//   meas_*          : values latched at the last frame boundary
//   frame_done      : one-cycle pulse when meas_* / frame_ok update
//   frame_ok        : last compare result
//   locked          : LOCK_FRAMES consecutive matching frames seen
//   err_cnt         : saturating count of mismatched frames and signal losses
//
// state   | meaning
// IDLE    | waiting for a vs fall; the partial frame in progress is ignored
// MEASURE | measuring frames, fewer than LOCK_FRAMES good frames in a row
// LOCKED  | measuring frames, timing stable and matching
module vga_timing_checker #(
  parameter int W            = vga_pkg::W,
  parameter int LOCK_FRAMES  = 3,
  parameter int TIMEOUT_CLKS = 8192
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         vga_hs,
  input  logic         vga_vs,
  input  logic         vga_de,
  input  logic [W-1:0] exp_h_period,
  input  logic [W-1:0] exp_h_active,
  input  logic [W-1:0] exp_v_period,
  input  logic [W-1:0] exp_v_active,
  output logic [W-1:0] meas_h_period,
  output logic [W-1:0] meas_h_active,
  output logic [W-1:0] meas_v_period,
  output logic [W-1:0] meas_v_active,
  output logic         frame_done,
  output logic         frame_ok,
  output logic         locked,
  output logic [15:0]  err_cnt
);

  import vga_pkg::*;

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam int           TOC_W   = $clog2(TIMEOUT_CLKS + 1);
  localparam int           GOOD_W  = $clog2(LOCK_FRAMES + 1);

  logic hs_fall, vs_fall, de_rise, de_fall, de_q1;
  logic unused_hs_q, unused_hs_rise, unused_vs_q, unused_vs_rise;

  sync_edge_det #(.IDLE_LVL(1'b1)) u_hs (
    .clk(clk), .reset(reset), .din(vga_hs),
    .q(unused_hs_q), .rise(unused_hs_rise), .fall(hs_fall)
  );
  sync_edge_det #(.IDLE_LVL(1'b1)) u_vs (
    .clk(clk), .reset(reset), .din(vga_vs),
    .q(unused_vs_q), .rise(unused_vs_rise), .fall(vs_fall)
  );
  sync_edge_det #(.IDLE_LVL(1'b0)) u_de (
    .clk(clk), .reset(reset), .din(vga_de),
    .q(de_q1), .rise(de_rise), .fall(de_fall)
  );

  state_t state_q, state_d;

  logic [W-1:0]      hcnt, acnt, vcnt, vacnt;
  logic [W-1:0]      last_period, last_active, h_ref, a_ref;
  logic              h_ref_vld, a_ref_vld, h_uneven, de_uneven, sat_flag;
  logic [TOC_W-1:0]  toc;
  logic [GOOD_W-1:0] good_cnt, good_d, good_inc;

  logic [W-1:0] line_period, fin_period, fin_active;
  logic         h_mis, a_mis, sat_now, match, timeout;
  logic         frame_start, do_latch, err_inc;

  assign line_period = hcnt + 1'b1;
  assign h_mis       = hs_fall && h_ref_vld && (line_period != h_ref);
  assign a_mis       = de_fall && a_ref_vld && (acnt != a_ref);
  assign sat_now     = (hcnt == CNT_MAX) || (acnt == CNT_MAX) ||
                       (vcnt == CNT_MAX) || (vacnt == CNT_MAX);

  // Values as they stand at the boundary, including an hs/de fall landing
  // in the same cycle as the vs fall (that line still belongs to the old frame).
  assign fin_period = hs_fall ? line_period : last_period;
  assign fin_active = de_fall ? acnt : last_active;

  assign match = (fin_period == exp_h_period) && (fin_active == exp_h_active) &&
                 (vcnt == exp_v_period) && (vacnt == exp_v_active) &&
                 !(h_uneven || h_mis) && !(de_uneven || a_mis) &&
                 !(sat_flag || sat_now);

  // Fires once, on the clock toc steps onto TIMEOUT_CLKS.
  assign timeout = !hs_fall && (toc == TOC_W'(TIMEOUT_CLKS - 1));

  assign good_inc = good_cnt + 1'b1;

  always_comb begin
    state_d     = state_q;
    good_d      = good_cnt;
    frame_start = 1'b0;
    do_latch    = 1'b0;
    err_inc     = 1'b0;
    if (timeout) begin
      state_d = IDLE;
      good_d  = '0;
      err_inc = (state_q != IDLE);
    end else if (vs_fall) begin
      frame_start = 1'b1;
      case (state_q)
        IDLE: state_d = MEASURE;
        MEASURE: begin
          do_latch = 1'b1;
          if (match) begin
            good_d = good_inc;
            if (good_inc >= GOOD_W'(LOCK_FRAMES)) state_d = LOCKED;
          end else begin
            good_d  = '0;
            err_inc = 1'b1;
          end
        end
        LOCKED: begin
          do_latch = 1'b1;
          if (!match) begin
            good_d  = '0;
            err_inc = 1'b1;
            state_d = MEASURE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      good_cnt <= '0;
    end else begin
      state_q  <= state_d;
      good_cnt <= good_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt        <= '0;
      acnt        <= '0;
      vcnt        <= '0;
      vacnt       <= '0;
      toc         <= '0;
      last_period <= '0;
      last_active <= '0;
      h_ref       <= '0;
      a_ref       <= '0;
      h_ref_vld   <= 1'b0;
      a_ref_vld   <= 1'b0;
      h_uneven    <= 1'b0;
      de_uneven   <= 1'b0;
      sat_flag    <= 1'b0;
    end else begin
      if (hs_fall) begin
        hcnt        <= '0;
        last_period <= line_period;
        toc         <= '0;
      end else begin
        if (hcnt != CNT_MAX) hcnt <= hcnt + 1'b1;
        if (toc != TOC_W'(TIMEOUT_CLKS)) toc <= toc + 1'b1;
      end

      if (frame_start || de_fall) acnt <= '0;
      else if (de_q1 && acnt != CNT_MAX) acnt <= acnt + 1'b1;

      if (frame_start) begin
        vcnt        <= hs_fall ? W'(1) : '0;
        vacnt       <= de_rise ? W'(1) : '0;
        last_active <= '0;
        h_ref_vld   <= 1'b0;
        a_ref_vld   <= 1'b0;
        h_uneven    <= 1'b0;
        de_uneven   <= 1'b0;
        sat_flag    <= 1'b0;
      end else begin
        if (hs_fall && vcnt != CNT_MAX) vcnt <= vcnt + 1'b1;
        if (de_rise && vacnt != CNT_MAX) vacnt <= vacnt + 1'b1;
        if (hs_fall && !h_ref_vld) begin
          h_ref     <= line_period;
          h_ref_vld <= 1'b1;
        end
        if (de_fall) begin
          last_active <= acnt;
          if (!a_ref_vld) begin
            a_ref     <= acnt;
            a_ref_vld <= 1'b1;
          end
        end
        if (h_mis) h_uneven <= 1'b1;
        if (a_mis) de_uneven <= 1'b1;
        if (sat_now) sat_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meas_h_period <= '0;
      meas_h_active <= '0;
      meas_v_period <= '0;
      meas_v_active <= '0;
      frame_done    <= 1'b0;
      frame_ok      <= 1'b0;
      locked        <= 1'b0;
      err_cnt       <= '0;
    end else begin
      frame_done <= do_latch;
      if (do_latch) begin
        meas_h_period <= fin_period;
        meas_h_active <= fin_active;
        meas_v_period <= vcnt;
        meas_v_active <= vacnt;
        frame_ok      <= match;
      end
      if (timeout) frame_ok <= 1'b0;
      locked <= (state_d == LOCKED);
      if (err_inc && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_timing_checker.sv
module tb_vga_timing_checker;
  import vga_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         vga_hs, vga_vs, vga_de;
  logic [W-1:0] exp_h_period, exp_h_active, exp_v_period, exp_v_active;
  logic [W-1:0] meas_h_period, meas_h_active, meas_v_period, meas_v_active;
  logic         frame_done, frame_ok, locked;
  logic [15:0]  err_cnt;

  vga_timing_checker #(.W(W), .LOCK_FRAMES(3), .TIMEOUT_CLKS(8192)) dut (
    .clk(clk), .reset(reset),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .exp_h_period(exp_h_period), .exp_h_active(exp_h_active),
    .exp_v_period(exp_v_period), .exp_v_active(exp_v_active),
    .meas_h_period(meas_h_period), .meas_h_active(meas_h_active),
    .meas_v_period(meas_v_period), .meas_v_active(meas_v_active),
    .frame_done(frame_done), .frame_ok(frame_ok), .locked(locked),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  typedef struct {
    int hp, ha, vp, va;
    bit ok, lk;
    int err;
    int cyc;
  } exp_t;
  exp_t sb[$];

  // reference model: 0 idle, 1 measuring, 2 locked
  int m_state = 0, m_good = 0, m_err = 0;
  int f_lines, f_first_len, f_last_len, f_de_lines, f_first_de, f_last_de;
  bit f_hun, f_dun;

  task automatic clear_stats();
    f_lines = 0; f_first_len = 0; f_last_len = 0;
    f_de_lines = 0; f_first_de = 0; f_last_de = 0;
    f_hun = 0; f_dun = 0;
  endtask

  task automatic frame_boundary();
    exp_t e;
    bit ok;
    if (m_state == 0) begin
      m_state = 1;
    end else begin
      ok = (f_last_len == int'(exp_h_period)) && (f_last_de == int'(exp_h_active)) &&
           (f_lines == int'(exp_v_period)) && (f_de_lines == int'(exp_v_active)) &&
           !f_hun && !f_dun;
      if (ok) begin
        if (m_state == 1) begin
          m_good++;
          if (m_good >= 3) m_state = 2;
        end
      end else begin
        m_good = 0;
        m_state = 1;
        if (m_err < 65535) m_err++;
      end
      e.hp = f_last_len; e.ha = f_last_de; e.vp = f_lines; e.va = f_de_lines;
      e.ok = ok; e.lk = (m_state == 2); e.err = m_err; e.cyc = cyc;
      sb.push_back(e);
    end
    clear_stats();
  endtask

  task automatic drive_line(input int len, input int de_w, input bit vs_low, input bit de_on);
    for (int x = 0; x < len; x++) begin
      vga_hs = (x < 2) ? 1'b0 : 1'b1;
      vga_vs = vs_low ? 1'b0 : 1'b1;
      vga_de = de_on && (x >= 4) && (x < 4 + de_w);
      @(negedge clk);
    end
    f_lines++;
    if (f_lines == 1) f_first_len = len;
    else if (len != f_first_len) f_hun = 1;
    f_last_len = len;
    if (de_on) begin
      f_de_lines++;
      if (f_de_lines == 1) f_first_de = de_w;
      else if (de_w != f_first_de) f_dun = 1;
      f_last_de = de_w;
    end
  endtask

  // 10-line frame: vs low on lines 0-1, de on lines 2-7; long_y gets a
  // 21-clk line, short_y an 11-clk de run; stop_y truncates the frame.
  task automatic drive_frame(input int long_y, input int short_y, input int stop_y);
    frame_boundary();
    for (int y = 0; y < stop_y; y++)
      drive_line((y == long_y) ? 21 : 20, (y == short_y) ? 11 : 12, y < 2, (y >= 2) && (y < 8));
  endtask

  task automatic idle_clks(input int n);
    vga_hs = 1'b1; vga_vs = 1'b1; vga_de = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic good_frames(input int n);
    for (int i = 0; i < n; i++) drive_frame(-1, -1, 10);
  endtask

  always @(negedge clk) begin
    if (!reset && frame_done) begin
      if (sb.size() == 0) begin
        chk("spurious_frame_done", 32'(frame_done), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_latency", 32'(cyc - e.cyc), 2);
        chk("meas_h_period", 32'(meas_h_period), 32'(e.hp));
        chk("meas_h_active", 32'(meas_h_active), 32'(e.ha));
        chk("meas_v_period", 32'(meas_v_period), 32'(e.vp));
        chk("meas_v_active", 32'(meas_v_active), 32'(e.va));
        chk("frame_ok", 32'(frame_ok), 32'(e.ok));
        chk("locked", 32'(locked), 32'(e.lk));
        chk("err_cnt", 32'(err_cnt), 32'(e.err));
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_meas_hp"}, 32'(meas_h_period), 0);
    chk({tag, "_meas_ha"}, 32'(meas_h_active), 0);
    chk({tag, "_meas_vp"}, 32'(meas_v_period), 0);
    chk({tag, "_meas_va"}, 32'(meas_v_active), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_frame_ok"}, 32'(frame_ok), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    vga_hs = 1'b1; vga_vs = 1'b1; vga_de = 1'b0;
    exp_h_period = W'(H_PERIOD_SIM);
    exp_h_active = W'(H_ACTIVE_SIM);
    exp_v_period = W'(V_PERIOD_SIM);
    exp_v_active = W'(V_ACTIVE_SIM);
    clear_stats();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    idle_clks(4);

    // nominal timing: lock after three good frames
    good_frames(5);
    chk("nominal_locked", 32'(locked), 1);

    // one 21-clk line while locked, then relock
    drive_frame(4, -1, 10);
    good_frames(4);

    // one short de run
    drive_frame(-1, 4, 10);
    good_frames(4);
    chk("pre_timeout_locked", 32'(locked), 1);

    // signal loss while locked
    idle_clks(8300);
    if (m_state != 0 && m_err < 65535) m_err++;
    m_state = 0; m_good = 0;
    clear_stats();
    chk("timeout_locked", 32'(locked), 0);
    chk("timeout_frame_ok", 32'(frame_ok), 0);
    chk("timeout_err_cnt", 32'(err_cnt), 32'(m_err));
    chk("timeout_meas_hold", 32'(meas_h_period), 20);
    good_frames(5);
    chk("relock_after_timeout", 32'(locked), 1);

    // expected active lines wrong: every frame mismatches
    exp_v_active = 7;
    good_frames(3);
    chk("bad_exp_not_locked", 32'(locked), 0);
    exp_v_active = W'(V_ACTIVE_SIM);
    good_frames(4);

    // reset mid-frame while locked
    drive_frame(-1, -1, 5);
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    m_state = 0; m_good = 0; m_err = 0;
    clear_stats();
    idle_clks(3);
    reset = 1'b0;
    idle_clks(5);
    good_frames(4);
    drive_frame(-1, -1, 1);
    idle_clks(10);

    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
